// File: rtl/crc_pkg.sv
`default_nettype none
// ==================================================================
// crc_pkg : state encoding, CRC constants and single-bit CRC step
// Rev 1.0
// ==================================================================
package crc_pkg;

   localparam int                   CRC_WIDTH = 8;
   localparam logic [CRC_WIDTH-1:0] CRC_POLY  = 8'h85;
   localparam int                   PAD_BITS  = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_BYTE = 3'd1,
      ST_SHIFT     = 3'd2,
      ST_PAD       = 3'd3,
      ST_DONE      = 3'd4
   } seq_state_e;

   // Augmented, non-reflected form: shift the new bit in, reduce on the outgoing MSB.
   function automatic logic [CRC_WIDTH-1:0] crc_step(input logic [CRC_WIDTH-1:0] rem,
                                                     input logic                 din);
      return {rem[CRC_WIDTH-2:0], din} ^ ({CRC_WIDTH{rem[CRC_WIDTH-1]}} & CRC_POLY);
   endfunction

endpackage
`default_nettype wire

// File: rtl/generate_crc.sv
`default_nettype none
// ==================================================================
// generate_crc : bit-serial CRC-8 engine, synchronous clear
// Rev 1.0
// ==================================================================
module generate_crc
   import crc_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 data,
   output logic [CRC_WIDTH-1:0] rem
);

   logic [CRC_WIDTH-1:0] rem_d;
   logic [CRC_WIDTH-1:0] rem_q;

   always_comb begin
      rem_d = rem_q;
      if (reset) begin
         rem_d = '0;
      end else if (enable) begin
         rem_d = crc_step(rem_q, data);
      end
   end

   always_ff @(posedge clk) begin
      rem_q <= rem_d;
   end

   assign rem = rem_q;

endmodule
`default_nettype wire

// File: rtl/crc_block_sequencer.sv
`default_nettype none
// ==================================================================
// crc_block_sequencer : feeds a fixed-length byte block MSB-first into
// generate_crc, appends the zero pad and checks the final remainder
// Rev 1.0
// ==================================================================
module crc_block_sequencer
   import crc_pkg::*;
#(
   parameter int BLOCK_BYTES = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] crc_expected,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       busy,
   output logic       crc_valid,
   output logic [7:0] crc_out,
   output logic       crc_match,
   input  logic       crc_ack,
   input  logic       abort
);

   localparam int                      BYTE_CNT_W   = $clog2(BLOCK_BYTES + 1);
   localparam logic [BYTE_CNT_W-1:0]   BLOCK_LAST   = BYTE_CNT_W'(BLOCK_BYTES);
   localparam logic [2:0]              PAD_LAST_BIT = 3'(PAD_BITS - 1);

   seq_state_e            state_d,    state_q;
   logic [2:0]            bit_cnt_d,  bit_cnt_q;
   logic [BYTE_CNT_W-1:0] byte_cnt_d, byte_cnt_q;
   logic [7:0]            shift_d,    shift_q;
   logic [7:0]            crc_exp_d,  crc_exp_q;
   logic [7:0]            crc_out_d,  crc_out_q;

   logic                  crc_clr;
   logic                  crc_en;
   logic                  crc_bit;
   logic [CRC_WIDTH-1:0]  crc_rem;
   logic [BYTE_CNT_W-1:0] byte_cnt_inc;

   assign byte_cnt_inc = byte_cnt_q + BYTE_CNT_W'(1);

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      crc_exp_d  = crc_exp_q;
      crc_out_d  = crc_out_q;
      crc_clr    = 1'b0;
      crc_en     = 1'b0;
      crc_bit    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            crc_clr = 1'b1;
            if (start) begin
               state_d    = ST_WAIT_BYTE;
               byte_cnt_d = '0;
               crc_exp_d  = crc_expected;
            end
         end

         ST_WAIT_BYTE: begin
            if (in_valid) begin
               shift_d   = in_data;
               bit_cnt_d = 3'd7;
               state_d   = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            crc_en  = 1'b1;
            crc_bit = shift_q[7];
            shift_d = {shift_q[6:0], 1'b0};
            if (bit_cnt_q == 3'd0) begin
               byte_cnt_d = byte_cnt_inc;
               if (byte_cnt_inc == BLOCK_LAST) begin
                  state_d   = ST_PAD;
                  bit_cnt_d = PAD_LAST_BIT;
               end else begin
                  state_d = ST_WAIT_BYTE;
               end
            end else begin
               bit_cnt_d = bit_cnt_q - 3'd1;
            end
         end

         ST_PAD: begin
            crc_en = 1'b1;
            if (bit_cnt_q == 3'd0) begin
               // The engine absorbs this last pad bit on the same edge, so capture its next value.
               crc_out_d = crc_step(crc_rem, 1'b0);
               state_d   = ST_DONE;
            end else begin
               bit_cnt_d = bit_cnt_q - 3'd1;
            end
         end

         ST_DONE: begin
            if (crc_ack) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (abort && (state_q != ST_IDLE)) begin
         state_d   = ST_IDLE;
         crc_out_d = crc_out_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 3'd0;
         byte_cnt_q <= '0;
         shift_q    <= 8'h00;
         crc_exp_q  <= 8'h00;
         crc_out_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
         crc_exp_q  <= crc_exp_d;
         crc_out_q  <= crc_out_d;
      end
   end

   generate_crc u_engine (
      .clk    (clk),
      .reset  (crc_clr),
      .enable (crc_en),
      .data   (crc_bit),
      .rem    (crc_rem)
   );

   assign in_ready  = (state_q == ST_WAIT_BYTE);
   assign busy      = (state_q != ST_IDLE);
   assign crc_valid = (state_q == ST_DONE);
   assign crc_out   = crc_out_q;
   assign crc_match = crc_valid && (crc_out_q == crc_exp_q);

endmodule
`default_nettype wire

// File: tb/tb_crc_block_sequencer.sv
`default_nettype none
// ==================================================================
// tb_crc_block_sequencer : directed bench, instances with 1, 32 and 4 byte blocks
// Rev 1.0
// ==================================================================
module tb_crc_block_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [2:0] start;
   logic [7:0] crc_expected;
   logic       in_valid;
   logic [7:0] in_data;
   logic       crc_ack;
   logic       abort;
   logic [2:0] in_ready;
   logic [2:0] busy;
   logic [2:0] crc_valid;
   logic [2:0] crc_match;
   logic [7:0] crc_out [3];

   int n_checks  = 0;
   int n_fail    = 0;
   int cycle_cnt = 0;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   // Index 0: 1-byte blocks, index 1: default 32-byte blocks, index 2: 4-byte blocks.
   crc_block_sequencer #(.BLOCK_BYTES(1)) u_b1 (
      .clk(clk), .reset(reset), .start(start[0]), .crc_expected(crc_expected),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[0]), .busy(busy[0]),
      .crc_valid(crc_valid[0]), .crc_out(crc_out[0]), .crc_match(crc_match[0]),
      .crc_ack(crc_ack), .abort(abort)
   );

   crc_block_sequencer u_b32 (
      .clk(clk), .reset(reset), .start(start[1]), .crc_expected(crc_expected),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[1]), .busy(busy[1]),
      .crc_valid(crc_valid[1]), .crc_out(crc_out[1]), .crc_match(crc_match[1]),
      .crc_ack(crc_ack), .abort(abort)
   );

   crc_block_sequencer #(.BLOCK_BYTES(4)) u_b4 (
      .clk(clk), .reset(reset), .start(start[2]), .crc_expected(crc_expected),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[2]), .busy(busy[2]),
      .crc_valid(crc_valid[2]), .crc_out(crc_out[2]), .crc_match(crc_match[2]),
      .crc_ack(crc_ack), .abort(abort)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int sel, input logic [7:0] exp_crc, output int t0);
      t0              = cycle_cnt;
      start[sel]      = 1'b1;
      crc_expected    = exp_crc;
      tick();
      start           = 3'b000;
      crc_expected    = 8'h5A;
   endtask

   task automatic send_byte(input int sel, input logic [7:0] b);
      bit got;
      got      = 1'b0;
      in_data  = b;
      in_valid = 1'b1;
      for (int k = 0; k < 40 && !got; k++) begin
         if (in_ready[sel]) got = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      check_eq("byte_accepted", {31'd0, got}, 32'd1);
   endtask

   task automatic wait_valid(input int sel, input int t0, output int lat);
      for (int k = 0; k < 400 && !crc_valid[sel]; k++) tick();
      check_eq("valid_seen", {31'd0, crc_valid[sel]}, 32'd1);
      lat = cycle_cnt - t0 + 1;
   endtask

   task automatic check_result(input int sel, input logic [7:0] exp_crc, input logic exp_match);
      int held;
      check_eq("crc_out", {24'd0, crc_out[sel]}, {24'd0, exp_crc});
      check_eq("crc_match", {31'd0, crc_match[sel]}, {31'd0, exp_match});
      held = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (crc_valid[sel]) held++;
      end
      check_eq("valid_held", held, 3);
      crc_ack = 1'b1;
      tick();
      crc_ack = 1'b0;
      check_eq("valid_after_ack", {31'd0, crc_valid[sel]}, 32'd0);
      check_eq("busy_after_ack", {31'd0, busy[sel]}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int lat;
      int en_cnt;
      int rdy_bad;
      int seen;

      reset        = 1'b1;
      start        = 3'b000;
      crc_expected = 8'h00;
      in_valid     = 1'b0;
      in_data      = 8'h00;
      crc_ack      = 1'b0;
      abort        = 1'b0;
      tick();
      tick();

      check_eq("rst_in_ready", {29'd0, in_ready}, 32'd0);
      check_eq("rst_busy", {29'd0, busy}, 32'd0);
      check_eq("rst_crc_valid", {29'd0, crc_valid}, 32'd0);
      check_eq("rst_crc_match", {29'd0, crc_match}, 32'd0);
      check_eq("rst_crc_out", {8'd0, crc_out[0], crc_out[1], crc_out[2]}, 32'd0);
      check_eq("rst_engine_en", {31'd0, u_b1.crc_en}, 32'd0);
      check_eq("rst_engine_clr", {31'd0, u_b1.crc_clr}, 32'd1);

      reset = 1'b0;
      tick();

      // Single-byte block: 0x80 followed by 8 pad zeros leaves 0x89.
      do_start(0, 8'h89, t0);
      check_eq("busy_after_start", {31'd0, busy[0]}, 32'd1);
      send_byte(0, 8'h80);
      wait_valid(0, t0, lat);
      check_eq("latency_1", lat, 1 + 9 * 1 + 8 + 1);
      check_result(0, 8'h89, 1'b1);

      do_start(0, 8'h85, t0);
      send_byte(0, 8'h01);
      wait_valid(0, t0, lat);
      check_result(0, 8'h85, 1'b1);

      do_start(0, 8'h00, t0);
      send_byte(0, 8'h81);
      wait_valid(0, t0, lat);
      check_result(0, 8'h0C, 1'b0);

      // Throttled input: five idle WAIT_BYTE cycles must not clock the engine.
      do_start(0, 8'h89, t0);
      en_cnt  = 0;
      rdy_bad = 0;
      for (int k = 0; k < 5; k++) begin
         if (u_b1.crc_en) en_cnt++;
         if (!in_ready[0]) rdy_bad++;
         tick();
      end
      check_eq("stall_engine_en", en_cnt, 0);
      check_eq("stall_ready_low", rdy_bad, 0);
      send_byte(0, 8'h80);
      wait_valid(0, t0, lat);
      check_eq("latency_stall", lat, 1 + 5 + 9 * 1 + 8 + 1);
      check_result(0, 8'h89, 1'b1);

      // Default 32-byte block of zeros against a non-zero expected value.
      do_start(1, 8'h01, t0);
      for (int i = 0; i < 32; i++) send_byte(1, 8'h00);
      wait_valid(1, t0, lat);
      check_eq("latency_32", lat, 1 + 9 * 32 + 8 + 1);
      check_result(1, 8'h00, 1'b0);

      // Abort in the 4th SHIFT cycle of byte 3.
      do_start(2, 8'h00, t0);
      send_byte(2, 8'h11);
      send_byte(2, 8'h22);
      send_byte(2, 8'h33);
      tick();
      tick();
      tick();
      check_eq("busy_before_abort", {31'd0, busy[2]}, 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_eq("abort_busy", {31'd0, busy[2]}, 32'd0);
      check_eq("abort_ready", {31'd0, in_ready[2]}, 32'd0);
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         if (crc_valid[2]) seen++;
         tick();
      end
      check_eq("abort_no_valid", seen, 0);

      // Clean 4-byte block 0x80,0,0,0 -> 0x89 -> 0xBF -> 0x0B -> 0xB9, with ignored start/in_valid in SHIFT.
      do_start(2, 8'hB9, t0);
      send_byte(2, 8'h80);
      start[2] = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hFF;
      check_eq("shift_ready_low", {31'd0, in_ready[2]}, 32'd0);
      tick();
      start    = 3'b000;
      in_valid = 1'b0;
      check_eq("shift_still_busy", {31'd0, busy[2]}, 32'd1);
      for (int i = 0; i < 3; i++) send_byte(2, 8'h00);
      wait_valid(2, t0, lat);
      check_eq("latency_4", lat, 1 + 9 * 4 + 8 + 1);
      check_result(2, 8'hB9, 1'b1);

      // Asynchronous reset between edges during PAD.
      do_start(2, 8'hB9, t0);
      send_byte(2, 8'h80);
      for (int i = 0; i < 3; i++) send_byte(2, 8'h00);
      for (int k = 0; k < 10; k++) tick();
      check_eq("pad_engine_en", {31'd0, u_b4.crc_en}, 32'd1);
      check_eq("pad_busy", {31'd0, busy[2]}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check_eq("arst_busy", {31'd0, busy[2]}, 32'd0);
      check_eq("arst_ready", {31'd0, in_ready[2]}, 32'd0);
      check_eq("arst_valid", {31'd0, crc_valid[2]}, 32'd0);
      check_eq("arst_crc_out", {24'd0, crc_out[2]}, 32'd0);
      check_eq("arst_match", {31'd0, crc_match[2]}, 32'd0);
      #2;
      reset = 1'b0;
      tick();
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         if (crc_valid[2] || busy[2]) seen++;
         tick();
      end
      check_eq("arst_no_partial", seen, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/crc_block_sequencer.md
# crc_block_sequencer

Byte-level controller that sequences the bit-serial `generate_crc` engine over a fixed-length data block, as required for controller-pak 32-byte block transfers. It accepts bytes over a valid/ready handshake and feeds them MSB-first into the engine. After the last byte it appends the mandatory 8 zero bits, then presents the final remainder. It also compares that remainder against an expected CRC byte supplied with the start command.

## Interface
- `BLOCK_BYTES`, default 32: bytes per block; legal range 1..255.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a block; sampled only in IDLE.
- `crc_expected`  in  8  expected CRC; captured on the accepted `start`.
- `in_valid`  in  1  `in_data` valid.
- `in_data`  in  8  data byte.
- `in_ready`  out  1  sequencer can accept a byte.
- `busy`  out  1  high in every state except IDLE.
- `crc_valid`  out  1  result valid; held until `crc_ack`.
- `crc_out`  out  8  final remainder.
- `crc_match`  out  1  `crc_out == crc_expected`; valid only while `crc_valid` is high.
- `crc_ack`  in  1  consumer acknowledges the result.
- `abort`  in  1  cancel the block in progress.

## Operation
- Engine contract for `generate_crc`:
  - Polynomial 0x85, initial remainder 0x00, augmented (non-reflected) form.
  - Each rising `clk` with `enable` high shifts `data` into `rem`.
  - `reset` high clears `rem` to 0.
- The sequencer drives the engine's `enable`, `data` and `reset` (crc_clr) directly.
- States:
  - IDLE: crc_clr held high. `start` → WAIT_BYTE; byte counter = 0; `crc_expected` captured.
  - WAIT_BYTE: `in_ready`=1. On `in_valid && in_ready`, load `in_data` into the shift register, set bit counter = 7, go to SHIFT.
  - SHIFT: `enable`=1, `data` = shift_reg[7]; shift left each cycle; 8 cycles. On the bit-counter-0 cycle the byte counter increments. If the byte counter then equals `BLOCK_BYTES`, go to PAD; else go to WAIT_BYTE.
  - PAD: `enable`=1, `data`=0 for exactly 8 cycles, then go to DONE.
  - DONE: `crc_valid`=1. `crc_out` is registered from the engine `rem` on entry. `crc_ack` → IDLE.
- `abort` in any non-IDLE state → IDLE next cycle. No result is produced; the engine is cleared on the IDLE entry.
- `start` outside IDLE is ignored. `in_valid` outside WAIT_BYTE is ignored; the byte is not consumed because `in_ready`=0.
- `abort` and `crc_ack` asserted in the same DONE cycle: both lead to IDLE, so the behaviour is identical.
- `abort` has priority over the handshake: if `abort` coincides with a WAIT_BYTE byte acceptance, the byte is dropped.
- Counter widths: bit counter 3 bits; byte counter `$clog2(BLOCK_BYTES+1)` bits. No wrap-around is permitted before the compare.

## Timing
- Reset values:
  - state=IDLE, `in_ready`=0, `busy`=0, `crc_valid`=0, `crc_out`=0x00, `crc_match`=0.
  - Engine enable=0; engine clear asserted.
- Throughput is 9 cycles per byte: 1 WAIT_BYTE cycle plus 8 SHIFT cycles, with back-to-back `in_valid`.
- Minimum latency from `start` accepted to `crc_valid` high is 1 + 9·BLOCK_BYTES + 8 + 1 cycles.
- `crc_valid` rises on the first DONE cycle and falls the cycle after `crc_ack`.
- `busy` rises the cycle after `start` and falls on IDLE entry.
- Asynchronous reset mid-block returns all outputs to reset values immediately. No partial result is reported.

## Structure
- Shared package `crc_pkg`:
  - state encoding typedef (IDLE, WAIT_BYTE, SHIFT, PAD, DONE);
  - `CRC_POLY` = 8'h85;
  - `CRC_WIDTH` = 8;
  - `PAD_BITS` = 8.
- Sub-module: the existing `generate_crc`, instantiated once as the engine. The FSM, counters and shift register live in this block.

## Test plan
- Single-byte block: BLOCK_BYTES=1, byte 0x80, `crc_expected`=0x89 → `crc_valid` after 19 cycles; `crc_out`=0x89; `crc_match`=1.
- Default block of 32 × 0x00, `crc_expected`=0x01 → `crc_out`=0x00; `crc_match`=0; `crc_valid` holds until `crc_ack`, then IDLE the next cycle.
- Throttled input: BLOCK_BYTES=1, `in_valid` low for 5 cycles in WAIT_BYTE, then 0x80 → same result as the single-byte case; no engine `enable` pulses during the stall.
- Abort in the 4th SHIFT cycle of byte 3 → IDLE next cycle; `busy`=0; `crc_valid` never asserted. A following full block of 0x80-then-zeros gives the clean-start result.
- Asynchronous `reset` pulse between clock edges during PAD → all outputs at reset values immediately. `start` while not IDLE, `in_valid` in SHIFT → ignored; byte count unaffected.
